board_renderer: RTL
===================

// Module: board_renderer
// PURPOSE
//  Reader side of the tetris core's display interface. Draws one frame of the 10x20
//  visible playfield as filled squares on a 160x120 3-bit pixel-plot VGA adapter.
//  Inputs: flat_board and the four active-block coordinates. Output: one pixel per clock.
//  Sits between the tetris core and the vga_adapter; frame pacing drives start_frame.
// PARAMETERS
//  CELL_SIZE      5       pixel edge of one board cell (square)
//  X_ORIGIN       55      screen x of the left edge of column 0
//  Y_ORIGIN       10      screen y of the top edge of row 19
//  COLOUR_EMPTY   3'b000  colour of an empty cell
//  COLOUR_FILLED  3'b111  colour of a dropped (board_state) cell
//  COLOUR_ACTIVE  3'b110  colour of a falling-tetromino cell
// PORTS
//  clock          in   1    system clock
//  resetn         in   1    reset, asynchronous, active-low
//  start_frame    in   1    request a frame; sampled only in IDLE
//  flat_board     in   230  board; cell (row r, col c) = flat_board[r*10+c]
//  block1_x..4_x  in   4    active block columns (0..9)
//  block1_y..4_y  in   5    active block rows (0..22)
//  vga_x          out  8    pixel x to adapter
//  vga_y          out  7    pixel y to adapter
//  colour         out  3    pixel colour to adapter
//  plot           out  1    write enable: vga_x/vga_y/colour valid this cycle
//  busy           out  1    frame in progress
//  frame_done     out  1    one-cycle pulse after the last pixel of a frame
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; vga_x, vga_y, colour, plot, busy, frame_done = 0.
//  All outputs are registered.
//  States: IDLE -> DRAW -> DONE -> IDLE.
//  IDLE: plot=0, busy=0. If start_frame=1 at edge N:
//   - snapshot flat_board[199:0] and all eight block coordinates;
//   - clear counters (row=19, col=0, py=0, px=0);
//   - enter DRAW.
//  DRAW: plot=1, busy=1 from cycle N+1. One pixel per clock.
//   - Nest order: row 19 down to 0; col 0..9; py 0..CELL_SIZE-1; px 0..CELL_SIZE-1 (innermost).
//   - vga_x = X_ORIGIN + col*CELL_SIZE + px.
//   - vga_y = Y_ORIGIN + (19-row)*CELL_SIZE + py.
//   - Compute in 9 bits, truncate to port width.
//   - colour priority: ACTIVE if any snapped block k has (x_k==col && y_k==row);
//     else FILLED if the snapshot bit is set; else EMPTY.
//   - Rows 20..22 and blocks with y>=20 are never drawn.
//   - Frame = 200*CELL_SIZE^2 plot cycles (5000 at default), N+1..N+5000.
//  DONE (cycle N+5001): plot=0, busy=0, frame_done=1 for one cycle; then IDLE.
//   - A start_frame seen in DONE is ignored.
//   - start_frame may be re-accepted at the earliest in the first IDLE cycle.
//  start_frame during DRAW/DONE is ignored; it is not queued.
//  Input changes during a frame do not affect the frame; the snapshot is used.
//  resetn low mid-frame: outputs drop immediately and no frame_done is issued.
//   - The next start_frame redraws from row 19, col 0.
// TESTING
//  1 Reset: hold resetn=0 -> plot=0, busy=0, frame_done=0, vga_x=0, vga_y=0, colour=0.
//    Release -> outputs stay idle until start_frame.
//  2 Empty board, all block_y=21, pulse start -> 5000 plots, all colour 000.
//    First pixel (55,10); last pixel (104,109); frame_done exactly once, cycle after last plot.
//  3 flat_board[0]=1 only -> colour 111 at x 55..59, y 105..109 (25 px); all other px 000.
//  4 Block at (4,19) and flat_board[194]=1 -> x 75..79, y 10..14 coloured 110 (active wins).
//    Block at y=20 -> not drawn.
//  5 Mid-frame: change flat_board and pulse start_frame -> image matches the start snapshot.
//    Total 5000 plots; one frame_done.
//  6 Assert resetn at plot 100 -> plot/busy 0 same cycle; no frame_done.
//    Restart -> first pixel (55,10).

Source files
------------

// File: rtl/board_renderer.sv
// Streams the 10x20 visible playfield to a pixel-plot VGA adapter,
// one pixel per clock, from a board/block snapshot taken at frame start.
module board_renderer #(
    parameter int         CELL_SIZE     = 5,
    parameter int         X_ORIGIN      = 55,
    parameter int         Y_ORIGIN      = 10,
    parameter logic [2:0] COLOUR_EMPTY  = 3'b000,
    parameter logic [2:0] COLOUR_FILLED = 3'b111,
    parameter logic [2:0] COLOUR_ACTIVE = 3'b110
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         start_frame,
    input  logic [229:0] flat_board,
    input  logic [3:0]   block1_x,
    input  logic [3:0]   block2_x,
    input  logic [3:0]   block3_x,
    input  logic [3:0]   block4_x,
    input  logic [4:0]   block1_y,
    input  logic [4:0]   block2_y,
    input  logic [4:0]   block3_y,
    input  logic [4:0]   block4_y,
    output logic [7:0]   vga_x,
    output logic [6:0]   vga_y,
    output logic [2:0]   colour,
    output logic         plot,
    output logic         busy,
    output logic         frame_done
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    localparam logic [3:0] PLAST = 4'(CELL_SIZE - 1);

    state_t          state_q;
    logic [199:0]    board_q;
    logic [3:0][3:0] bx_q;
    logic [3:0][4:0] by_q;
    logic [4:0]      row_q, row_d;
    logic [3:0]      col_q, col_d;
    logic [3:0]      py_q, py_d;
    logic [3:0]      px_q, px_d;

    logic [199:0]    src_board;
    logic [3:0][3:0] src_bx;
    logic [3:0][4:0] src_by;
    logic [3:0][3:0] live_bx;
    logic [3:0][4:0] live_by;
    logic [7:0]      idx;
    logic            active;
    logic [2:0]      colour_d;
    logic [8:0]      x_d, y_d;
    logic            frame_last;
    logic            idle;
    logic            unused_bits;

    assign live_bx = {block4_x, block3_x, block2_x, block1_x};
    assign live_by = {block4_y, block3_y, block2_y, block1_y};
    assign idle    = (state_q == IDLE);

    // The first pixel is produced on the snapshot edge, so it reads live inputs.
    assign src_board = idle ? flat_board[199:0] : board_q;
    assign src_bx    = idle ? live_bx : bx_q;
    assign src_by    = idle ? live_by : by_q;

    assign frame_last = (row_q == 5'd0) && (col_q == 4'd9)
                     && (py_q == PLAST) && (px_q == PLAST);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        py_d  = py_q;
        px_d  = px_q;
        if (idle) begin
            row_d = 5'd19;
            col_d = 4'd0;
            py_d  = 4'd0;
            px_d  = 4'd0;
        end else if (px_q != PLAST) begin
            px_d = px_q + 4'd1;
        end else begin
            px_d = 4'd0;
            if (py_q != PLAST) begin
                py_d = py_q + 4'd1;
            end else begin
                py_d = 4'd0;
                if (col_q != 4'd9) begin
                    col_d = col_q + 4'd1;
                end else begin
                    col_d = 4'd0;
                    row_d = row_q - 5'd1;
                end
            end
        end
    end

    always_comb begin
        active = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (src_bx[k] == col_d && src_by[k] == row_d) begin
                active = 1'b1;
            end
        end
        idx = 8'(row_d) * 8'd10 + 8'(col_d);
        if (active) begin
            colour_d = COLOUR_ACTIVE;
        end else if (src_board[idx]) begin
            colour_d = COLOUR_FILLED;
        end else begin
            colour_d = COLOUR_EMPTY;
        end
        x_d = 9'(X_ORIGIN) + 9'(col_d) * 9'(CELL_SIZE) + 9'(px_d);
        y_d = 9'(Y_ORIGIN) + (9'd19 - 9'(row_d)) * 9'(CELL_SIZE)
            + 9'(py_d);
    end

    assign unused_bits = ^{flat_board[229:200], x_d[8], y_d[8:7]};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            board_q    <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            py_q       <= '0;
            px_q       <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    plot       <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                    if (start_frame) begin
                        board_q <= flat_board[199:0];
                        bx_q    <= live_bx;
                        by_q    <= live_by;
                        row_q   <= row_d;
                        col_q   <= col_d;
                        py_q    <= py_d;
                        px_q    <= px_d;
                        vga_x   <= x_d[7:0];
                        vga_y   <= y_d[6:0];
                        colour  <= colour_d;
                        plot    <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= DRAW;
                    end
                end
                DRAW: begin
                    if (frame_last) begin
                        plot       <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        row_q  <= row_d;
                        col_q  <= col_d;
                        py_q   <= py_d;
                        px_q   <= px_d;
                        vga_x  <= x_d[7:0];
                        vga_y  <= y_d[6:0];
                        colour <= colour_d;
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
